blackjack_game_ctrl: RTL

Game controller for the BlackJack design, sitting directly downstream of the four `switch_driver` instances. It consumes their single-cycle card one-shot pulses, draws a card rank from a free-running LFSR for each accepted pulse, and keeps the hand total with soft-ace handling. It decides win or lose and produces the `w_win_pulse`/`w_lose_pulse` pulses plus the score/rank values consumed by the LED and 7-segment logic.

---
 rtl/blackjack_game_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/blackjack_game_ctrl.sv
// rtl/blackjack_game_ctrl.sv - blackjack hand controller: card draw, soft-ace scoring, win/lose decision
module blackjack_game_ctrl #(
    parameter logic [7:0] SEED   = 8'hA5,
    parameter int         TARGET = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       first_card_os,
    input  logic       second_card_os,
    input  logic       third_card_os,
    input  logic       fourth_card_os,
    input  logic       force_en,
    input  logic [3:0] force_rank,
    output logic       win_pulse,
    output logic       lose_pulse,
    output logic       game_over,
    output logic [4:0] score,
    output logic [3:0] last_rank,
    output logic [2:0] card_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HAND,
        S_EVAL,
        S_DONE
    } state_t;

    localparam logic [5:0] TARGET_V = 6'(TARGET);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q;
    logic [5:0] hard_q, hard_d;
    logic       ace_q, ace_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] rank_q, rank_d;
    logic [4:0] score_q, score_d;
    logic       win_q, win_d;
    logic       lose_q, lose_d;
    logic       over_q, over_d;

    logic [3:0] raw_rank;
    logic [3:0] drawn_rank;
    logic [5:0] card_val;
    logic       pulse_expected;
    logic       accept;
    logic [5:0] base_hard;
    logic       base_ace;
    logic [2:0] base_cnt;
    logic [5:0] new_hard;
    logic       new_ace;
    logic [5:0] new_best;
    logic [5:0] cur_best;

    // Ace counts as 11 whenever that keeps the hand at or under 21
    function automatic logic [5:0] best_of(input logic [5:0] h, input logic a);
        return (a && (h <= 6'd11)) ? h + 6'd10 : h;
    endfunction

    function automatic logic [4:0] sat31(input logic [5:0] b);
        return (b > 6'd31) ? 5'd31 : b[4:0];
    endfunction

    // Free-running Fibonacci LFSR used as the card source
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    // Rank selection and mapping of the 4-bit source onto 1..13, plus card value
    always_comb begin
        raw_rank = force_en ? force_rank : lfsr_q[3:0];
        if (raw_rank == 4'd0) begin
            drawn_rank = 4'd1;
        end else if (raw_rank >= 4'd14) begin
            drawn_rank = raw_rank - 4'd3;
        end else begin
            drawn_rank = raw_rank;
        end
        if (drawn_rank >= 4'd11) begin
            card_val = 6'd10;
        end else begin
            card_val = {2'b00, drawn_rank};
        end
    end

    // Only the pulse for the next card slot is honoured; DONE accepts card 1 as a restart
    always_comb begin
        case (cnt_q)
            3'd0:    pulse_expected = first_card_os;
            3'd1:    pulse_expected = second_card_os;
            3'd2:    pulse_expected = third_card_os;
            3'd3:    pulse_expected = fourth_card_os;
            default: pulse_expected = 1'b0;
        endcase
        if (state_q == S_DONE) begin
            accept    = first_card_os;
            base_hard = 6'd0;
            base_ace  = 1'b0;
            base_cnt  = 3'd0;
        end else begin
            accept    = (state_q != S_EVAL) && pulse_expected;
            base_hard = hard_q;
            base_ace  = ace_q;
            base_cnt  = cnt_q;
        end
        new_hard = base_hard + card_val;
        new_ace  = base_ace | (drawn_rank == 4'd1);
        new_best = best_of(new_hard, new_ace);
        cur_best = best_of(hard_q, ace_q);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        hard_d  = hard_q;
        ace_d   = ace_q;
        cnt_d   = cnt_q;
        rank_d  = rank_q;
        score_d = score_q;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        over_d  = over_q;
        case (state_q)
            S_IDLE, S_HAND, S_DONE: begin
                if (accept) begin
                    state_d = S_EVAL;
                    hard_d  = new_hard;
                    ace_d   = new_ace;
                    cnt_d   = base_cnt + 3'd1;
                    rank_d  = drawn_rank;
                    score_d = sat31(new_best);
                    over_d  = 1'b0;
                end
            end
            S_EVAL: begin
                if (cur_best > 6'd21) begin
                    lose_d  = 1'b1;
                    over_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cur_best == 6'd21) begin
                    win_d   = 1'b1;
                    over_d  = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == 3'd4) begin
                    win_d   = (cur_best >= TARGET_V);
                    lose_d  = (cur_best < TARGET_V);
                    over_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_HAND;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Game state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            hard_q  <= 6'd0;
            ace_q   <= 1'b0;
            cnt_q   <= 3'd0;
            rank_q  <= 4'd0;
            score_q <= 5'd0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hard_q  <= hard_d;
            ace_q   <= ace_d;
            cnt_q   <= cnt_d;
            rank_q  <= rank_d;
            score_q <= score_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            over_q  <= over_d;
        end
    end

    assign win_pulse  = win_q;
    assign lose_pulse = lose_q;
    assign game_over  = over_q;
    assign score      = score_q;
    assign last_rank  = rank_q;
    assign card_cnt   = cnt_q;

endmodule
